// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and
// MEM/WB operand forwarding into the ALU and the EX/MEM store-data path.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_shamt,
    input  logic [2:0]  id_alu_op,
    input  logic        id_alu_src_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        flush,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        stall,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_alu_op,
    output logic [4:0]  ex_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_store_data
);

    logic [4:0]  ex_rs_r;
    logic [4:0]  ex_rt_r;
    logic [31:0] ex_rs_data_r;
    logic [31:0] ex_rt_data_r;
    logic [31:0] ex_imm_r;
    logic        ex_alu_src_imm_r;
    logic        hz_s;
    logic        bubble_s;
    logic [31:0] fwd_rs_s;
    logic [31:0] fwd_rt_s;

    // MEM result wins over WB; register 0 is hardwired and never forwarded.
    function automatic logic [31:0] forward_sel(
        input logic [4:0]  idx,
        input logic [31:0] reg_data,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_data,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_data
    );
        logic [31:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == idx)) begin
            sel = m_data;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == idx)) begin
            sel = w_data;
        end else begin
            sel = reg_data;
        end
        return sel;
    endfunction

    // Load-use hazard against the load sitting in EX, and the resulting bubble request.
    always_comb begin
        hz_s = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
        stall    = hz_s & ~flush;
        bubble_s = flush | hz_s;
    end

    // Pipeline register: reset, bubble on flush/hazard, otherwise capture ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid         <= 1'b0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            ex_pc            <= 32'd0;
            ex_rd            <= 5'd0;
            ex_alu_op        <= 3'd0;
            ex_shamt         <= 5'd0;
            ex_rs_r          <= 5'd0;
            ex_rt_r          <= 5'd0;
            ex_rs_data_r     <= 32'd0;
            ex_rt_data_r     <= 32'd0;
            ex_imm_r         <= 32'd0;
            ex_alu_src_imm_r <= 1'b0;
        end else if (bubble_s) begin
            ex_valid         <= 1'b0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            ex_pc            <= 32'd0;
            ex_rd            <= 5'd0;
            ex_alu_op        <= 3'd0;
            ex_shamt         <= 5'd0;
            ex_rs_r          <= 5'd0;
            ex_rt_r          <= 5'd0;
            ex_rs_data_r     <= 32'd0;
            ex_rt_data_r     <= 32'd0;
            ex_imm_r         <= 32'd0;
            ex_alu_src_imm_r <= 1'b0;
        end else begin
            ex_valid         <= id_valid;
            ex_reg_write     <= id_reg_write & id_valid;
            ex_mem_read      <= id_mem_read & id_valid;
            ex_mem_write     <= id_mem_write & id_valid;
            ex_mem_to_reg    <= id_mem_to_reg & id_valid;
            ex_pc            <= id_pc;
            ex_rd            <= id_rd;
            ex_alu_op        <= id_alu_op;
            ex_shamt         <= id_shamt;
            ex_rs_r          <= id_rs;
            ex_rt_r          <= id_rt;
            ex_rs_data_r     <= id_rs_data;
            ex_rt_data_r     <= id_rt_data;
            ex_imm_r         <= id_imm;
            ex_alu_src_imm_r <= id_alu_src_imm & id_valid;
        end
    end

    // Forwarded operands; store data always takes the forwarded rt value.
    always_comb begin
        fwd_rs_s = forward_sel(ex_rs_r, ex_rs_data_r, mem_reg_write, mem_rd, mem_result,
                               wb_reg_write, wb_rd, wb_result);
        fwd_rt_s = forward_sel(ex_rt_r, ex_rt_data_r, mem_reg_write, mem_rd, mem_result,
                               wb_reg_write, wb_rd, wb_result);
        alu_a         = fwd_rs_s;
        ex_store_data = fwd_rt_s;
        if (ex_alu_src_imm_r) begin
            alu_b = ex_imm_r;
        end else begin
            alu_b = fwd_rt_s;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_uses_rt, id_alu_src_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [2:0]  id_alu_op;
    logic        flush, mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_rd, ex_shamt;
    logic [2:0]  ex_alu_op;

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        uses_rt;
        logic [2:0]  op;
        logic        src_imm, reg_write, mem_read, mem_write, mem_to_reg;
        logic        flush, mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct packed {
        logic        stall, valid, reg_write, mem_read, mem_write, mem_to_reg;
        logic [31:0] pc;
        logic [4:0]  rd, shamt;
        logic [2:0]  op;
        logic [31:0] a, b, sd;
    } exp_t;

    exp_t   exp_q[$];
    stim_t  m;           // instruction currently held in EX (model)
    int     n_chk = 0;
    int     n_pass = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] held,
                                             input stim_t s);
        if (idx != 5'd0 && s.mem_we && s.mem_rd == idx) return s.mem_res;
        if (idx != 5'd0 && s.wb_we && s.wb_rd == idx) return s.wb_res;
        return held;
    endfunction

    // Does the ID instruction need the result of a load still in EX?
    function automatic logic needs_load(input stim_t s);
        if (!m.valid || !m.mem_read || m.rd == 5'd0 || !s.valid) return 1'b0;
        return (m.rd == s.rs) || (s.uses_rt && m.rd == s.rt);
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        e.stall      = needs_load(s) && !s.flush;
        e.valid      = m.valid;
        e.reg_write  = m.reg_write;
        e.mem_read   = m.mem_read;
        e.mem_write  = m.mem_write;
        e.mem_to_reg = m.mem_to_reg;
        e.pc         = m.pc;
        e.rd         = m.rd;
        e.shamt      = m.shamt;
        e.op         = m.op;
        e.a          = value_of(m.rs, m.rs_data, s);
        e.sd         = value_of(m.rt, m.rt_data, s);
        e.b          = m.src_imm ? m.imm : e.sd;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst_n = s.rst_n; id_valid = s.valid; id_pc = s.pc;
        id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_shamt = s.shamt;
        id_uses_rt = s.uses_rt; id_alu_op = s.op; id_alu_src_imm = s.src_imm;
        id_reg_write = s.reg_write; id_mem_read = s.mem_read;
        id_mem_write = s.mem_write; id_mem_to_reg = s.mem_to_reg; flush = s.flush;
        mem_reg_write = s.mem_we; mem_rd = s.mem_rd; mem_result = s.mem_res;
        wb_reg_write = s.wb_we; wb_rd = s.wb_rd; wb_result = s.wb_res;
    endtask

    // One cycle: apply inputs, queue the expected response, advance the model at the edge.
    task automatic step(input stim_t s);
        logic hz;
        drive(s);
        if (!s.rst_n) m = '0;
        exp_q.push_back(predict(s));
        hz = needs_load(s);
        @(posedge clk);
        if (!s.rst_n || s.flush || hz) begin
            m = '0;
        end else begin
            m = s;
            m.reg_write  = s.reg_write & s.valid;
            m.mem_read   = s.mem_read & s.valid;
            m.mem_write  = s.mem_write & s.valid;
            m.mem_to_reg = s.mem_to_reg & s.valid;
            m.src_imm    = s.src_imm & s.valid;
        end
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n = ($urandom_range(0, 63) != 0);
        s.valid = ($urandom_range(0, 3) != 0);
        s.pc = $urandom; s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
        s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
        s.rd = 5'($urandom_range(0, 7)); s.shamt = 5'($urandom);
        s.uses_rt = 1'($urandom); s.op = 3'($urandom); s.src_imm = 1'($urandom);
        s.reg_write = 1'($urandom); s.mem_read = 1'($urandom);
        s.mem_write = 1'($urandom); s.mem_to_reg = 1'($urandom);
        s.flush = ($urandom_range(0, 7) == 0);
        s.mem_we = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 7)); s.mem_res = $urandom;
        s.wb_we = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 7)); s.wb_res = $urandom;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(e.reg_write));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mem_read));
            chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mem_write));
            chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.mem_to_reg));
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_rd", 32'(ex_rd), 32'(e.rd));
            chk("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
            chk("ex_shamt", 32'(ex_shamt), 32'(e.shamt));
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("ex_store_data", ex_store_data, e.sd);
        end
    end

    initial begin
        stim_t s;
        m = '0;
        drive('0);
        @(posedge clk); #1;

        // reset held with a live ID instruction, then released
        s = '0; s.valid = 1'b1; s.reg_write = 1'b1; s.op = 3'b101; s.pc = 32'h100;
        s.rd = 5'd3; s.rs = 5'd1; s.rs_data = 32'h55;
        step(s); step(s);
        s.rst_n = 1'b1;
        step(s); step(s);

        // MEM over WB priority, then WB alone, then r0 never forwarded
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.rs = 5'd5; s.rs_data = 32'h99;
        s.mem_we = 1'b1; s.mem_rd = 5'd5; s.mem_res = 32'h11;
        s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_res = 32'h22;
        step(s); step(s);
        s.mem_we = 1'b0; step(s);
        s.rs = 5'd0; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_we = 1'b1; step(s); step(s);

        // immediate on B, forwarded rt on store data
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.src_imm = 1'b1; s.imm = 32'hFFFF_FFF0;
        s.rt = 5'd7; s.rt_data = 32'h44; s.mem_write = 1'b1;
        s.mem_we = 1'b1; s.mem_rd = 5'd7; s.mem_res = 32'h33;
        step(s); step(s);

        // load-use: lw r4, dependent add, then WB forward
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.mem_read = 1'b1; s.reg_write = 1'b1;
        s.rd = 5'd4; step(s);
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.rs = 5'd4; s.rd = 5'd6; s.reg_write = 1'b1;
        step(s); step(s);
        s.valid = 1'b0; s.wb_we = 1'b1; s.wb_rd = 5'd4; s.wb_res = 32'hABCD; step(s);

        // rt not used as a source: no stall
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.mem_read = 1'b1; s.rd = 5'd4; step(s);
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.rt = 5'd4; s.rs = 5'd2; step(s);

        // flush coincident with a hazard
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.mem_read = 1'b1; s.rd = 5'd4; step(s);
        s = '0; s.rst_n = 1'b1; s.valid = 1'b1; s.rs = 5'd4; s.reg_write = 1'b1;
        s.flush = 1'b1; step(s);
        s.flush = 1'b0; s.valid = 1'b0; s.mem_write = 1'b1; step(s);
        step(s);

        for (int i = 0; i < 2000; i++) step(rand_stim());

        s = '0; s.rst_n = 1'b1; step(s);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage CPU, sitting directly upstream of the ALU. It registers decoded instruction fields and controls from ID, detects load-use hazards and inserts bubbles, and applies flushes. It drives the ALU's A/B/op/shamt inputs through MEM/WB forwarding muxes, and also drives the store-data and control bundle to the EX/MEM register.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits, ALU op 3 bits.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  32  PC of ID instruction
- id_rs_data, id_rt_data  in  32 each  register file read data
- id_imm  in  32  extended immediate
- id_rs, id_rt, id_rd  in  5 each  source and destination indices; id_rd is the final write index
- id_uses_rt  in  1  instruction reads rt as a source
- id_shamt  in  5  shift amount
- id_alu_op  in  3  ALU operation code, ALU encoding
- id_alu_src_imm  in  1  ALU B takes the immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  controls
- flush  in  1  squash ID instruction (taken branch/jump)
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_rd  in  5  MEM-stage destination
- mem_result  in  32  MEM-stage ALU result
- wb_reg_write  in  1  WB-stage instruction writes a register
- wb_rd  in  5  WB-stage destination
- wb_result  in  32  WB write data
- stall  out  1  freeze PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls
- ex_pc  out  32  registered PC
- ex_rd  out  5  registered destination
- ex_alu_op  out  3  to ALU ALU_operation
- ex_shamt  out  5  to ALU shamt
- alu_a, alu_b  out  32 each  to ALU A and B, after forwarding
- ex_store_data  out  32  forwarded rt value for stores

## Operation
- Internal state: one register per ex_* output, plus ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm and ex_alu_src_imm.
- Load-use detect (combinational): hz = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- stall = hz & ~flush. A flushed ID instruction never stalls.
- Update priority at each clock edge:
  - 1: rst_n low.
  - 2: flush or hz: load a bubble.
  - 3: otherwise, load the id_* fields. ex_valid = id_valid; all controls are ANDed with id_valid.
- Bubble: every register is 0. ex_valid=0, all controls 0, ex_alu_op=000, data and indices 0.
- Forwarding, per source s∈{rs,rt}, using registered index ex_s:
  - If mem_reg_write & mem_rd≠0 & mem_rd==ex_s, use mem_result.
  - Else if wb_reg_write & wb_rd≠0 & wb_rd==ex_s, use wb_result.
  - Else use ex_s_data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b = ex_imm if ex_alu_src_imm, else forwarded rt.
  - ex_store_data = forwarded rt, independent of ex_alu_src_imm.
- Shifts: ALU shifts B by shamt. For shift instructions, ID must route the operand on rt with ex_alu_src_imm=0.
- The block does no arithmetic.

## Timing
- Reset: all registers 0 asynchronously. All ex_* outputs are 0, and alu_a, alu_b and ex_store_data follow forwarding from zeroed state. stall is 0 while ex_valid=0.
- Latency: ID fields appear on ex_* one cycle after capture.
- alu_a, alu_b, ex_store_data and stall are combinational in the same cycle as the mem_*/wb_* inputs. There is no extra register.
- A load-use pair costs exactly one bubble:
  - Cycle n: stall=1.
  - Cycle n+1: ex_valid=0 and the load is in MEM. The dependent instruction is re-presented, hz=0, and it is captured.
  - Cycle n+2: operand is forwarded from WB (wb_result).
- Flush and hz in the same cycle: bubble, stall=0.
- Reset deasserted mid-program: the first capture happens on the first rising edge with rst_n high.

## Test plan
- Reset: rst_n=0 with id_valid=1 and id_reg_write=1 -> ex_valid=0, ex_reg_write=0, ex_alu_op=000, stall=0. Then release -> next edge loads the ID fields.
- MEM/WB priority:
  - ex_rs=5, mem_rd=5 (mem_result=0x11), wb_rd=5 (wb_result=0x22), both writes=1 -> alu_a=0x11.
  - Drop mem_reg_write -> alu_a=0x22.
  - Same inputs with ex_rs=0 -> alu_a=ex_rs_data.
- Immediate select: ex_alu_src_imm=1, ex_imm=0xFFFF_FFF0, rt forwarded 0x33 -> alu_b=0xFFFF_FFF0, ex_store_data=0x33.
- Load-use:
  - lw to r4 in EX (ex_rd=4), ID with id_rs=4 -> stall=1. Next edge ex_valid=0.
  - Cycle after: instruction captured. With wb_rd=4, wb_result=0xABCD -> alu_a=0xABCD.
  - id_uses_rt=0 with id_rt=4 -> no stall.
- Flush: flush=1 together with a load-use hazard -> stall=0, and next cycle ex_valid=0 with all controls 0.
- Bubble on invalid ID: id_valid=0, id_mem_write=1 -> ex_mem_write=0 after the edge.
